timer_counter: RTL and testbench
================================

# timer_counter

8-bit count stage of the timer, directly downstream of `clock_select`. It detects rising edges of the selected divided clock (pclk/2, /4, /8 or /16), all in the `pclk` domain. On each such edge it advances an up/down counter. It supports synchronous load from the data register and raises sticky overflow and underflow flags for the register/interrupt logic.

## Interface
- `WIDTH`, 8, counter width; all values below assume 8.
- `pclk`  in  1  system clock; the only clock.
- `presetn`  in  1  reset, synchronous, active-low.
- `clock_select`  in  1  divided clock level from `clock_select`, synchronous to `pclk`.
- `en`  in  1  count enable (TCR.EN).
- `up_dn`  in  1  1 = count up, 0 = count down.
- `load`  in  1  one-cycle pulse: load `tdr` into counter.
- `tdr`  in  8  load value.
- `clr_ovf`  in  1  one-cycle pulse: clear `ovf`.
- `clr_udf`  in  1  one-cycle pulse: clear `udf`.
- `tcnt`  out  8  counter value, registered.
- `ovf`  out  1  sticky overflow flag, registered.
- `udf`  out  1  sticky underflow flag, registered.
- `tick`  out  1  one-cycle pulse, registered: the counter advanced this cycle.

## Operation
- **Edge detect.** `clk_d` <= `clock_select` every cycle, regardless of `en`. The edge cycle is any cycle with `clock_select`=1 and `clk_d`=0. Falling edges are ignored.
- **FSM states:**
  - STOP: `en`=0. The counter holds; `load` is still honoured.
  - RUN: `en`=1.
  - STOP->RUN when `en`=1. RUN->STOP when `en`=0, effective the same cycle; an edge in that cycle is not counted.
  - `clk_d` keeps tracking in STOP. Enabling while `clock_select` is already high gives no count until the next rising edge.
- **Advance:** occurs in RUN on an edge cycle with `load`=0.
  - Up: `tcnt`+1. FF->00 wraps and sets `ovf`.
  - Down: `tcnt`-1. 00->FF wraps and sets `udf`.
  - Arithmetic is modulo 256, with no saturation.
- **Priority:** reset > load > advance.
  - `load` in an edge cycle writes `tdr`; that edge is discarded and `tick` stays 0.
  - `load` never sets `ovf` or `udf`, including a load of 00 or FF.
- **Flags:**
  - Set has priority over clear when both occur in the same cycle.
  - A clear pulse with the flag already 0 has no effect.
  - `ovf` and `udf` are independent.
- **`up_dn` changes** take effect at the next edge. Wrap detection uses the direction sampled in the edge cycle.
- **Reset values** (`presetn`=0 at a `pclk` edge): `tcnt`=00, `ovf`=0, `udf`=0, `tick`=0, `clk_d`=0, FSM=STOP.
  - Reset mid-count aborts immediately; no partial state is kept.
  - After release, the first count needs a fresh rising edge. If `clock_select` is high in the first cycle after release, `clk_d`=0 makes that cycle count as an edge cycle.

## Timing
- **Latency:** edge cycle N -> new `tcnt`, `tick`=1 and any flag set are all visible in cycle N+1.
- **`tick`** is high for exactly one cycle per advance.
- **Count rate:** one increment per divided period.
  - pclk/2: every 2 cycles.
  - pclk/16: every 16 cycles.
- **`load`:** `tcnt`=`tdr` in cycle N+1.
- **`clr_*`:** flag reads 0 in cycle N+1 unless a set occurs in cycle N.
- No combinational path from any input to any output.

## Test plan
1. **Reset:** `presetn`=0 for 5 cycles with `clock_select` toggling and `en`=1 -> `tcnt`=00, `ovf`=`udf`=`tick`=0 throughout. After release, with `clock_select` held at pclk/2 and `en`=1, `up_dn`=1 -> `tcnt` reaches 0A after 10 rising edges (20 cycles), and `tick` pulses 10 times.
2. **Overflow:** load `tdr`=FE, up, 2 edges -> `tcnt` FE->FF->00 and `ovf`=1 from the cycle `tcnt`=00. `ovf` stays 1 for 3 more edges. `clr_ovf` pulse -> `ovf`=0 next cycle.
3. **Underflow:** load 01, `up_dn`=0, 2 edges -> 01->00->FF and `udf`=1, with `ovf` unchanged. A load of FF afterwards does not touch the flags.
4. **Load/edge collision:** `load`=1, `tdr`=80 in an edge cycle while running up from 10 -> `tcnt`=80 next cycle (not 11 or 81), `tick`=0. The next edge gives 81.
5. **Enable gating:** `en`=0 mid-count at 33 with edges continuing -> `tcnt` stays 33. Raise `en` while `clock_select`=1 -> no change until the next rising edge, then 34.
6. **Flag collision and reset:** `clr_ovf`=1 in the FF->00 wrap edge cycle -> `ovf`=1. Assert `presetn`=0 mid-count at 5A with `ovf`=1 -> next cycle `tcnt`=00, `ovf`=0.

Source files
------------

// File: rtl/timer_counter.sv
// timer_counter: 8-bit up/down count stage of the timer.
//
// Detects rising edges of the divided clock level from clock_select (all in the pclk domain)
// and advances the counter once per rising edge while enabled. Supports a synchronous load
// and keeps sticky overflow/underflow flags for the register/interrupt logic.
//
// Ports:
//   pclk_i          system clock, the only clock
//   presetn_i       synchronous active-low reset
//   clock_select_i  divided clock level, synchronous to pclk_i
//   en_i            count enable
//   up_dn_i         1 = count up, 0 = count down
//   load_i          one-cycle pulse: load tdr_i into the counter
//   tdr_i           load value
//   clr_ovf_i       one-cycle pulse: clear ovf_o
//   clr_udf_i       one-cycle pulse: clear udf_o
//   tcnt_o          counter value (registered)
//   ovf_o           sticky overflow flag (registered)
//   udf_o           sticky underflow flag (registered)
//   tick_o          one-cycle pulse (registered): the counter advanced in the previous cycle
module timer_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             pclk_i,
    input  logic             presetn_i,
    input  logic             clock_select_i,
    input  logic             en_i,
    input  logic             up_dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] tdr_i,
    input  logic             clr_ovf_i,
    input  logic             clr_udf_i,
    output logic [WIDTH-1:0] tcnt_o,
    output logic             ovf_o,
    output logic             udf_o,
    output logic             tick_o
);

    typedef enum logic {StStop, StRun} state_e;

    state_e           state_q, state_d;
    logic             clk_d_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             tick_q, tick_d;

    logic             rise;
    logic             run;

    // clk_d_q tracks the level every cycle, even when stopped, so enabling while the
    // divided clock is already high waits for a fresh rising edge.
    assign rise = clock_select_i & ~clk_d_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStop:  if (en_i)  state_d = StRun;
            StRun:   if (!en_i) state_d = StStop;
            default: state_d = StStop;
        endcase
    end

    // Leaving RUN takes effect in the same cycle, so gate on the next state.
    assign run = (state_d == StRun);

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        // Clears apply first; a set below overrides a same-cycle clear.
        ovf_d  = ovf_q & ~clr_ovf_i;
        udf_d  = udf_q & ~clr_udf_i;

        if (load_i) begin
            // Load wins over a coincident edge; the edge is discarded and flags untouched.
            cnt_d = tdr_i;
        end else if (run && rise) begin
            tick_d = 1'b1;
            if (up_dn_i) begin
                cnt_d = cnt_q + WIDTH'(1);
                if (cnt_q == {WIDTH{1'b1}}) ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
                if (cnt_q == '0) udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q <= StStop;
            clk_d_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_d_q <= clock_select_i;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            tick_q  <= tick_d;
        end
    end

    assign tcnt_o = cnt_q;
    assign ovf_o  = ovf_q;
    assign udf_o  = udf_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed testbench for timer_counter. Inputs change 1 ns after each rising pclk edge and
// outputs are sampled at the same point, i.e. they reflect the edge just taken.
module tb_timer_counter;

    logic       pclk;
    logic       presetn;
    logic       clock_select;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] tdr;
    logic       clr_ovf;
    logic       clr_udf;
    logic [7:0] tcnt;
    logic       ovf;
    logic       udf;
    logic       tick;

    int checks = 0;
    int errors = 0;
    int tick_cnt;

    timer_counter #(.WIDTH(8)) dut (
        .pclk_i         (pclk),
        .presetn_i      (presetn),
        .clock_select_i (clock_select),
        .en_i           (en),
        .up_dn_i        (up_dn),
        .load_i         (load),
        .tdr_i          (tdr),
        .clr_ovf_i      (clr_ovf),
        .clr_udf_i      (clr_udf),
        .tcnt_o         (tcnt),
        .ovf_o          (ovf),
        .udf_o          (udf),
        .tick_o         (tick)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full outputs: {tcnt, ovf, udf, tick}
    function automatic logic [31:0] st();
        return {21'd0, tcnt, ovf, udf, tick};
    endfunction

    function automatic logic [31:0] ex(input logic [7:0] c, input logic o, input logic u,
                                       input logic t);
        return {21'd0, c, o, u, t};
    endfunction

    initial begin
        presetn = 1'b0; clock_select = 1'b0; en = 1'b1; up_dn = 1'b1;
        load = 1'b0; tdr = 8'h00; clr_ovf = 1'b0; clr_udf = 1'b0;

        // 1. Reset with toggling divided clock and enable high
        for (int i = 0; i < 5; i++) begin
            clock_select = ~clock_select;
            cyc();
            chk("reset_hold", st(), ex(8'h00, 1'b0, 1'b0, 1'b0));
        end
        presetn = 1'b1;
        tick_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            clock_select = 1'b1;
            cyc();
            if (tick) tick_cnt++;
            chk("count_up_edge", st(), ex(8'(i + 1), 1'b0, 1'b0, 1'b1));
            clock_select = 1'b0;
            cyc();
            if (tick) tick_cnt++;
            chk("count_up_low", {31'd0, tick}, 32'd0);
        end
        chk("count_up_final", {24'd0, tcnt}, 32'h0A);
        chk("tick_pulses", tick_cnt, 10);

        // 2. Overflow
        load = 1'b1; tdr = 8'hFE;
        cyc();
        load = 1'b0;
        chk("load_fe", st(), ex(8'hFE, 1'b0, 1'b0, 1'b0));
        clock_select = 1'b1; cyc(); clock_select = 1'b0;
        chk("up_to_ff", st(), ex(8'hFF, 1'b0, 1'b0, 1'b1));
        cyc();
        clock_select = 1'b1; cyc(); clock_select = 1'b0;
        chk("wrap_ovf", st(), ex(8'h00, 1'b1, 1'b0, 1'b1));
        cyc();
        for (int i = 0; i < 3; i++) begin
            clock_select = 1'b1; cyc(); clock_select = 1'b0; cyc();
        end
        chk("ovf_sticky", st(), ex(8'h03, 1'b1, 1'b0, 1'b0));
        clr_ovf = 1'b1; cyc(); clr_ovf = 1'b0;
        chk("clr_ovf", st(), ex(8'h03, 1'b0, 1'b0, 1'b0));

        // 3. Underflow
        load = 1'b1; tdr = 8'h01; up_dn = 1'b0;
        cyc();
        load = 1'b0;
        clock_select = 1'b1; cyc(); clock_select = 1'b0;
        chk("down_to_00", st(), ex(8'h00, 1'b0, 1'b0, 1'b1));
        cyc();
        clock_select = 1'b1; cyc(); clock_select = 1'b0;
        chk("wrap_udf", st(), ex(8'hFF, 1'b0, 1'b1, 1'b1));
        load = 1'b1; tdr = 8'hFF;
        cyc();
        load = 1'b0;
        chk("load_ff_flags", st(), ex(8'hFF, 1'b0, 1'b1, 1'b0));
        load = 1'b1; tdr = 8'h00;
        cyc();
        load = 1'b0;
        chk("load_00_flags", st(), ex(8'h00, 1'b0, 1'b1, 1'b0));
        clr_udf = 1'b1; clr_ovf = 1'b1; cyc(); clr_udf = 1'b0; clr_ovf = 1'b0;
        chk("clr_udf", st(), ex(8'h00, 1'b0, 1'b0, 1'b0));

        // 4. Load/edge collision while running up from 10
        up_dn = 1'b1;
        load = 1'b1; tdr = 8'h10;
        cyc();
        load = 1'b1; tdr = 8'h80; clock_select = 1'b1;
        cyc();
        load = 1'b0; clock_select = 1'b0;
        chk("load_collision", st(), ex(8'h80, 1'b0, 1'b0, 1'b0));
        cyc();
        clock_select = 1'b1; cyc(); clock_select = 1'b0;
        chk("after_collision", st(), ex(8'h81, 1'b0, 1'b0, 1'b1));
        cyc();

        // 5. Enable gating at 33
        load = 1'b1; tdr = 8'h33;
        cyc();
        load = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clock_select = 1'b1; cyc();
            chk("stopped_edge", st(), ex(8'h33, 1'b0, 1'b0, 1'b0));
            clock_select = 1'b0; cyc();
        end
        clock_select = 1'b1; cyc();
        en = 1'b1; cyc();
        chk("enable_high_level", st(), ex(8'h33, 1'b0, 1'b0, 1'b0));
        cyc();
        chk("enable_high_level2", st(), ex(8'h33, 1'b0, 1'b0, 1'b0));
        clock_select = 1'b0; cyc();
        clock_select = 1'b1; cyc(); clock_select = 1'b0;
        chk("enable_next_edge", st(), ex(8'h34, 1'b0, 1'b0, 1'b1));
        cyc();

        // pclk/4 rate: 2 increments in 8 cycles, tick asserted exactly twice
        tick_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            clock_select = (i % 4) < 2;
            cyc();
            if (tick) tick_cnt++;
        end
        chk("div4_count", {24'd0, tcnt}, 32'h36);
        chk("div4_ticks", tick_cnt, 2);
        clock_select = 1'b0; cyc();

        // 6. Set beats clear, then reset mid-count
        load = 1'b1; tdr = 8'hFF;
        cyc();
        load = 1'b0;
        clock_select = 1'b1; clr_ovf = 1'b1;
        cyc();
        clock_select = 1'b0; clr_ovf = 1'b0;
        chk("set_beats_clear", st(), ex(8'h00, 1'b1, 1'b0, 1'b1));
        cyc();
        load = 1'b1; tdr = 8'h5A;
        cyc();
        load = 1'b0;
        chk("load_5a", st(), ex(8'h5A, 1'b1, 1'b0, 1'b0));
        clock_select = 1'b1; presetn = 1'b0;
        cyc();
        chk("reset_mid_count", st(), ex(8'h00, 1'b0, 1'b0, 1'b0));
        presetn = 1'b1; clock_select = 1'b1;
        cyc();
        chk("edge_after_release", st(), ex(8'h01, 1'b0, 1'b0, 1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
